// File: rtl/regfile_wr_arbiter_if.sv
// Bus between the writeback requesters and the register-file write arbiter.
// Handshake: requester i transfers when req_valid[i] & req_ready[i] are both
// high at a rising clk edge; a requester holds valid/adr/data stable until
// it sees its ready bit.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 2,
  parameter int NREQ   = 3,
  parameter int CNT_W  = 16
);
  logic                     hold;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*ADDR_W-1:0]   req_adr;
  logic [NREQ*DATA_W-1:0]   req_data;
  logic [NREQ-1:0]          req_ready;
  logic [ADDR_W-1:0]        read_adr_a;
  logic [ADDR_W-1:0]        read_adr_b;
  logic                     pend_a;
  logic                     pend_b;
  logic                     write_en;
  logic [ADDR_W-1:0]        write_adr;
  logic [DATA_W-1:0]        write_data;
  logic [CNT_W-1:0]         conflict_cnt;
  logic                     clr_cnt;

  // Requester / environment side.
  modport master (
    output hold, req_valid, req_adr, req_data, read_adr_a, read_adr_b, clr_cnt,
    input  req_ready, pend_a, pend_b, write_en, write_adr, write_data, conflict_cnt
  );

  // Arbiter side.
  modport slave (
    input  hold, req_valid, req_adr, req_data, read_adr_a, read_adr_b, clr_cnt,
    output req_ready, pend_a, pend_b, write_en, write_adr, write_data, conflict_cnt
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port. The winning
// request is registered onto write_en/write_adr/write_data, read hazards are
// flagged while that write is in flight, and contended cycles are counted.
module regfile_wr_arbiter #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 2,
  parameter int NREQ   = 3,
  parameter int CNT_W  = 16,
  parameter int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  regfile_wr_arbiter_if.slave bus,
  output logic [PTR_W-1:0] dbg_rr_ptr_o
);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              write_en_q;
  logic [ADDR_W-1:0] write_adr_q;
  logic [DATA_W-1:0] write_data_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [NREQ-1:0]   grant;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_data;
  logic              contended;

  // Search from rr_ptr upward (mod NREQ); first valid requester wins.
  always_comb begin
    int idx;
    int nxt;
    grant     = '0;
    grant_any = 1'b0;
    sel_adr   = '0;
    sel_data  = '0;
    rr_ptr_d  = rr_ptr_q;
    idx       = 0;
    nxt       = 0;
    if (!rst && !bus.hold) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!grant_any && bus.req_valid[idx]) begin
          grant_any  = 1'b1;
          grant[idx] = 1'b1;
          sel_adr    = bus.req_adr[idx*ADDR_W +: ADDR_W];
          sel_data   = bus.req_data[idx*DATA_W +: DATA_W];
          nxt        = idx + 1;
          if (nxt == NREQ) nxt = 0;
          rr_ptr_d   = PTR_W'(nxt);
        end
      end
    end
  end

  assign contended = !bus.hold && ($countones(bus.req_valid) > 1);

  // Register the granted write; adr/data hold when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en_q   <= 1'b0;
      write_adr_q  <= '0;
      write_data_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      write_en_q <= grant_any;
      rr_ptr_q   <= rr_ptr_d;
      if (grant_any) begin
        write_adr_q  <= sel_adr;
        write_data_q <= sel_data;
      end
    end
  end

  // Saturating contention counter; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      cnt_q <= '0;
    end else if (contended && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.req_ready    = grant;
  assign bus.write_en     = write_en_q;
  assign bus.write_adr    = write_adr_q;
  assign bus.write_data   = write_data_q;
  assign bus.conflict_cnt = cnt_q;
  // The register file only captures the write at the end of the cycle, so a
  // read of the same address in that cycle sees the old value.
  assign bus.pend_a       = write_en_q && (write_adr_q == bus.read_adr_a);
  assign bus.pend_b       = write_en_q && (write_adr_q == bus.read_adr_b);
  assign dbg_rr_ptr_o     = rr_ptr_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural round-robin / register-file model.
module tb_regfile_wr_arbiter;
  localparam int DW = 48;
  localparam int AW = 2;
  localparam int NR = 3;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .NREQ(NR), .CNT_W(CW)) bus ();
  logic [1:0] dbg_ptr;

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREQ(NR), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dbg_rr_ptr_o (dbg_ptr)
  );

  // ---------------- stimulus state ----------------
  logic [NR-1:0] r_valid = '0;
  logic [AW-1:0] r_adr [NR] = '{default: '0};
  logic [DW-1:0] r_data[NR] = '{default: '0};
  logic [AW-1:0] rd_a = '0;
  logic [AW-1:0] rd_b = '0;
  logic          hold_r = 1'b0;
  logic          clr_r = 1'b0;

  assign bus.req_valid  = r_valid;
  assign bus.req_adr    = {r_adr[2], r_adr[1], r_adr[0]};
  assign bus.req_data   = {r_data[2], r_data[1], r_data[0]};
  assign bus.read_adr_a = rd_a;
  assign bus.read_adr_b = rd_b;
  assign bus.hold       = hold_r;
  assign bus.clr_cnt    = clr_r;

  // Register file driven by the DUT write port.
  logic [DW-1:0] rf[4] = '{default: '0};
  always @(posedge clk) if (bus.write_en) rf[bus.write_adr] <= bus.write_data;

  // ---------------- reference model ----------------
  int            m_ptr;
  bit            m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_data;
  int            m_cnt;
  logic [DW-1:0] exp_rf[4] = '{default: '0};
  int            last_g = -1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 0;
    m_adr  = '0;
    m_data = '0;
    m_cnt  = 0;
  endtask

  function automatic int model_grant();
    int i;
    if (rst || hold_r) return -1;
    for (int k = 0; k < NR; k++) begin
      i = (m_ptr + k) % NR;
      if (r_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: check combinational outputs, step model at the edge,
  // then check registered outputs and register-file contents.
  task automatic cycle();
    int g;
    int nv;
    logic [NR-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("pend_a", bus.pend_a, m_we && (m_adr == rd_a));
    chk("pend_b", bus.pend_b, m_we && (m_adr == rd_b));
    nv = 0;
    for (int i = 0; i < NR; i++) nv += int'(r_valid[i]);
    @(posedge clk);
    if (m_we) exp_rf[m_adr] = m_data;
    m_we = (g >= 0);
    if (g >= 0) begin
      m_adr  = r_adr[g];
      m_data = r_data[g];
      m_ptr  = (g + 1) % NR;
    end
    if (clr_r) m_cnt = 0;
    else if (!hold_r && nv >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
    last_g = g;
    #1;
    chk("write_en", bus.write_en, m_we);
    chk("write_adr", bus.write_adr, m_adr);
    chk("write_data", bus.write_data, m_data);
    chk("conflict_cnt", bus.conflict_cnt, m_cnt);
    chk("rr_ptr", dbg_ptr, m_ptr);
    for (int a = 0; a < 4; a++) chk("regfile", rf[a], exp_rf[a]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    model_reset();

    // ---- reset state (requests present but reset held) ----
    r_valid = 3'b111;
    #3;
    chk("ready_in_rst", bus.req_ready, 3'b000);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_write_en", bus.write_en, 0);
    chk("rst_write_adr", bus.write_adr, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_cnt", bus.conflict_cnt, 0);
    chk("rst_ptr", dbg_ptr, 0);
    rst = 1'b0;
    r_valid = 3'b000;

    // ---- single requester ----
    r_adr[1] = 2'd2; r_data[1] = 48'h3; r_valid = 3'b010;
    #1;
    chk("single_ready", bus.req_ready, 3'b010);
    cycle();
    r_valid = 3'b000;
    chk("single_we", bus.write_en, 1);
    chk("single_adr", bus.write_adr, 2);
    chk("single_data", bus.write_data, 48'h3);
    rd_a = 2'd2;
    cycle();
    chk("single_we_drop", bus.write_en, 0);
    chk("single_read", rf[rd_a], 48'h3);

    // ---- rotation (first move pointer to 0 via requester 2) ----
    r_adr[0] = 2'd0; r_data[0] = 48'h1;
    r_adr[1] = 2'd1; r_data[1] = 48'h2;
    r_adr[2] = 2'd2; r_data[2] = 48'h3;
    r_valid = 3'b100;
    cycle();
    chk("rot_ptr0", dbg_ptr, 0);
    r_valid = 3'b111;
    c0 = int'(bus.conflict_cnt);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rot_adr", bus.write_adr, k % 3);
      chk("rot_cnt", bus.conflict_cnt, c0 + k + 1);
    end

    // ---- hold ----
    r_valid = 3'b001; hold_r = 1'b1;
    c0 = int'(bus.conflict_cnt);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_ready", bus.req_ready, 3'b000);
      cycle();
      chk("hold_we", bus.write_en, 0);
    end
    hold_r = 1'b0;
    #1;
    chk("hold_release_ready", bus.req_ready, 3'b001);
    cycle();
    chk("hold_cnt", bus.conflict_cnt, c0);
    r_valid = 3'b000;

    // ---- hazard flags ----
    r_adr[0] = 2'd3; r_data[0] = 48'hABCD_0000_1234; r_valid = 3'b001;
    rd_a = 2'd3; rd_b = 2'd1;
    cycle();
    r_valid = 3'b000;
    chk("haz_pend_a", bus.pend_a, 1);
    chk("haz_pend_b", bus.pend_b, 0);
    cycle();
    chk("haz_pend_a_clear", bus.pend_a, 0);

    // ---- asynchronous reset mid-write ----
    r_adr[1] = 2'd0; r_data[1] = 48'hABC; r_valid = 3'b010;
    cycle();
    chk("mid_we", bus.write_en, 1);
    chk("mid_ptr", dbg_ptr, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we", bus.write_en, 0);
    chk("arst_ptr", dbg_ptr, 0);
    chk("arst_ready", bus.req_ready, 3'b000);
    model_reset();
    @(posedge clk); #1;
    chk("arst_rf_untouched", rf[0], exp_rf[0]);
    rst = 1'b0;
    r_valid = 3'b111;
    #1;
    chk("post_rst_ready", bus.req_ready, 3'b001);
    cycle();

    // ---- counter saturation and clear ----
    r_valid = 3'b011;
    for (int k = 0; k < 20; k++) cycle();
    chk("cnt_sat", bus.conflict_cnt, 15);
    clr_r = 1'b1;
    cycle();
    chk("cnt_clr", bus.conflict_cnt, 0);
    clr_r = 1'b0;
    cycle();
    chk("cnt_after_clr", bus.conflict_cnt, 1);

    // ---- random traffic ----
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!r_valid[i] || last_g == i) begin
          r_valid[i] = 1'($urandom_range(0, 1));
          r_adr[i]   = 2'($urandom_range(0, 3));
          r_data[i]  = {16'($urandom), 32'($urandom)};
        end
      end
      hold_r = ($urandom_range(0, 5) == 0);
      clr_r  = ($urandom_range(0, 30) == 0);
      rd_a   = 2'($urandom_range(0, 3));
      rd_b   = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
